ysyx_24100012_csr_file: RTL and testbench

//  Machine-mode CSR register file: the storage end of the CSR datapath. Supplies the old CSR value t (ALU in_a)
//  and commits the ALU privileged result (t|x, t&~x, x) back on writeback. Also owns ecall/mret trap state
//  (mepc, mcause, mstatus stacking), the redirect targets, and a free-running 64-bit mcycle counter.

---
 rtl/ysyx_24100012_csr_file.sv | 116 +++++++++++
 tb/tb_ysyx_24100012_csr_file.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_csr_file.sv
// Machine-mode CSR storage: combinational old-value read, one-edge writeback,
// ecall/mret trap stacking and a free-running 64-bit mcycle counter.
module ysyx_24100012_csr_file #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] MVENDORID   = 32'h79737978,
  parameter logic [DATA_WIDTH-1:0] MARCHID     = 32'h016F9A7C,
  parameter logic [DATA_WIDTH-1:0] MSTATUS_RST = 32'h00001800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] csr_addr,
  input  logic                  csr_ren,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic                  csr_wen,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_illegal,
  input  logic                  ecall,
  input  logic                  mret,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] trap_pc,
  output logic [DATA_WIDTH-1:0] ret_pc
);
  localparam logic [ADDR_WIDTH-1:0] A_MSTATUS  = 12'h300;
  localparam logic [ADDR_WIDTH-1:0] A_MTVEC    = 12'h305;
  localparam logic [ADDR_WIDTH-1:0] A_MSCRATCH = 12'h340;
  localparam logic [ADDR_WIDTH-1:0] A_MEPC     = 12'h341;
  localparam logic [ADDR_WIDTH-1:0] A_MCAUSE   = 12'h342;
  localparam logic [ADDR_WIDTH-1:0] A_MCYCLE   = 12'hB00;
  localparam logic [ADDR_WIDTH-1:0] A_MCYCLEH  = 12'hB80;
  localparam logic [ADDR_WIDTH-1:0] A_MVENDOR  = 12'hF11;
  localparam logic [ADDR_WIDTH-1:0] A_MARCHID  = 12'hF12;
  localparam logic [DATA_WIDTH-1:0] MS_MASK    = 32'h00001888;
  localparam logic [DATA_WIDTH-1:0] ALIGN4     = ~32'h3;

  logic [DATA_WIDTH-1:0]   mstatus, mtvec, mscratch, mepc, mcause;
  logic [DATA_WIDTH-1:0]   mstatus_n, mtvec_n, mscratch_n, mepc_n, mcause_n;
  logic [2*DATA_WIDTH-1:0] mcycle, mcycle_n;
  logic                    known, ro, wr;
  logic [DATA_WIDTH-1:0]   cyc_lo_inc;

  always_comb begin
    csr_rdata = '0;
    known     = 1'b1;
    ro        = 1'b0;
    case (csr_addr)
      A_MSTATUS:  csr_rdata = mstatus;
      A_MTVEC:    csr_rdata = mtvec;
      A_MSCRATCH: csr_rdata = mscratch;
      A_MEPC:     csr_rdata = mepc;
      A_MCAUSE:   csr_rdata = mcause;
      A_MCYCLE:   csr_rdata = mcycle[DATA_WIDTH-1:0];
      A_MCYCLEH:  csr_rdata = mcycle[2*DATA_WIDTH-1:DATA_WIDTH];
      A_MVENDOR:  begin csr_rdata = MVENDORID; ro = 1'b1; end
      A_MARCHID:  begin csr_rdata = MARCHID;   ro = 1'b1; end
      default:    known = 1'b0;
    endcase
  end

  assign csr_illegal = ((csr_ren | csr_wen) & ~known) | (csr_wen & ro);
  assign wr          = csr_wen & known & ~ro;
  assign trap_pc     = mtvec;
  assign ret_pc      = mepc;
  assign cyc_lo_inc  = mcycle[DATA_WIDTH-1:0] + 1'b1;

  // ecall beats mret beats the CSR write on every field the events touch.
  always_comb begin
    mstatus_n  = mstatus;
    mtvec_n    = mtvec;
    mscratch_n = mscratch;
    mepc_n     = mepc;
    mcause_n   = mcause;
    mcycle_n   = mcycle + 1'b1;
    if (wr) begin
      case (csr_addr)
        A_MSTATUS:  mstatus_n  = (mstatus & ~MS_MASK) | (csr_wdata & MS_MASK);
        A_MTVEC:    mtvec_n    = csr_wdata & ALIGN4;
        A_MSCRATCH: mscratch_n = csr_wdata;
        A_MEPC:     mepc_n     = csr_wdata & ALIGN4;
        A_MCAUSE:   mcause_n   = csr_wdata;
        A_MCYCLE:   mcycle_n   = {mcycle[2*DATA_WIDTH-1:DATA_WIDTH], csr_wdata};
        A_MCYCLEH:  mcycle_n   = {csr_wdata, cyc_lo_inc};
        default:    ;
      endcase
    end
    if (ecall) begin
      mstatus_n[7]     = mstatus[3];
      mstatus_n[3]     = 1'b0;
      mstatus_n[12:11] = 2'b11;
      mepc_n           = pc & ALIGN4;
      mcause_n         = DATA_WIDTH'(11);
    end else if (mret) begin
      mstatus_n[3]     = mstatus[7];
      mstatus_n[7]     = 1'b1;
      mstatus_n[12:11] = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus  <= MSTATUS_RST;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
    end else begin
      mstatus  <= mstatus_n;
      mtvec    <= mtvec_n;
      mscratch <= mscratch_n;
      mepc     <= mepc_n;
      mcause   <= mcause_n;
      mcycle   <= mcycle_n;
    end
  end
endmodule

// File: tb/tb_ysyx_24100012_csr_file.sv
// Self-checking bench for the CSR file: randomized traffic against a field-level reference model.
module tb_ysyx_24100012_csr_file;
  localparam logic [31:0] MVID = 32'h79737978;
  localparam logic [31:0] MAID = 32'h016F9A7C;
  localparam logic [31:0] MASK = 32'h00001888;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, csr_ren, csr_wen, csr_illegal, ecall, mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, csr_wdata, pc, trap_pc, ret_pc;

  ysyx_24100012_csr_file dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_ren(csr_ren), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_illegal(csr_illegal),
    .ecall(ecall), .mret(mret), .pc(pc), .trap_pc(trap_pc), .ret_pc(ret_pc)
  );

  int checks = 0, failures = 0;

  logic [31:0] m_status, m_tvec, m_scratch, m_epc, m_cause;
  logic [63:0] m_cycle;

  function automatic bit m_known(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hF11, 12'hF12};
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return a inside {12'hF11, 12'hF12};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_status;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hF11: return MVID;
      12'hF12: return MAID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h1800; m_tvec = 0; m_scratch = 0; m_epc = 0; m_cause = 0; m_cycle = 0;
  endtask

  task automatic idle();
    csr_ren = 0; csr_wen = 0; csr_wdata = 0; csr_addr = 12'h000; ecall = 0; mret = 0; pc = 0;
  endtask

  // Advance one clock edge and apply the architectural effect of the current inputs to the model.
  task automatic cycle();
    logic [31:0] st, tv, sc, ep, ca;
    logic [63:0] cy;
    bit w;
    w  = csr_wen && m_known(csr_addr) && !m_ro(csr_addr);
    st = m_status; tv = m_tvec; sc = m_scratch; ep = m_epc; ca = m_cause;
    cy = m_cycle + 64'd1;
    if (w && csr_addr == 12'h305) tv = {csr_wdata[31:2], 2'b00};
    if (w && csr_addr == 12'h340) sc = csr_wdata;
    if (w && csr_addr == 12'hB00) cy = {m_cycle[63:32], csr_wdata};
    if (w && csr_addr == 12'hB80) cy = {csr_wdata, m_cycle[31:0] + 32'd1};
    if (ecall) begin
      st[7] = m_status[3]; st[3] = 1'b0; st[12:11] = 2'b11;
      ep = {pc[31:2], 2'b00};
      ca = 32'd11;
    end else begin
      if (mret) begin
        st[3] = m_status[7]; st[7] = 1'b1; st[12:11] = 2'b11;
      end else if (w && csr_addr == 12'h300) st = (m_status & ~MASK) | (csr_wdata & MASK);
      if (w && csr_addr == 12'h341) ep = {csr_wdata[31:2], 2'b00};
      if (w && csr_addr == 12'h342) ca = csr_wdata;
    end
    @(posedge clk); #1;
    m_status = st; m_tvec = tv; m_scratch = sc; m_epc = ep; m_cause = ca; m_cycle = cy;
  endtask

  task automatic write(input logic [11:0] a, input logic [31:0] d);
    idle(); csr_wen = 1; csr_addr = a; csr_wdata = d;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340, 12'hF11};
    logic [31:0] exp   [6] = '{32'h1800, 32'h0, 32'h0, 32'h0, 32'h0, MVID};
    idle();
    rst = 0; #3;
    model_reset();
    checks++;
    if (trap_pc !== 32'h0 || ret_pc !== 32'h0) begin
      failures++; $display("FAIL reset_pcs trap_pc=%h ret_pc=%h required 0/0", trap_pc, ret_pc);
    end
    @(posedge clk); #1; rst = 1; #1;
    for (int i = 0; i < 6; i++) begin
      csr_ren = 1; csr_addr = addrs[i]; #1;
      checks++;
      if (csr_rdata !== exp[i] || csr_illegal !== 1'b0) begin
        failures++;
        $display("FAIL reset_read addr=%h rdata=%h illegal=%b required %h/0", addrs[i], csr_rdata, csr_illegal, exp[i]);
      end
    end
    idle();
  endtask

  task automatic test_write();
    logic [11:0] rw [7] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80};
    write(12'h305, 32'h8000_0103);
    csr_addr = 12'h305; #1;
    checks++;
    if (csr_rdata !== 32'h8000_0100) begin
      failures++; $display("FAIL mtvec_align rdata=%h required 80000100", csr_rdata);
    end
    write(12'h300, 32'hFFFF_FFFF);
    csr_addr = 12'h300; #1;
    checks++;
    if (csr_rdata !== 32'h0000_1888) begin
      failures++; $display("FAIL mstatus_mask rdata=%h required 00001888", csr_rdata);
    end
    for (int i = 0; i < 24; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = rw[$urandom_range(0, 6)];
      d = $urandom;
      idle(); csr_wen = 1; csr_addr = a; csr_wdata = d; #1;
      checks++;
      if (csr_rdata !== m_read(a)) begin
        failures++; $display("FAIL no_bypass addr=%h rdata=%h required %h", a, csr_rdata, m_read(a));
      end
      cycle(); idle();
      csr_addr = a; #1;
      checks++;
      if (csr_rdata !== m_read(a)) begin
        failures++; $display("FAIL rand_write addr=%h rdata=%h required %h", a, csr_rdata, m_read(a));
      end
    end
  endtask

  task automatic test_ecall_mret();
    write(12'h300, 32'h0000_1808);
    write(12'h305, 32'h8000_0100);
    idle(); ecall = 1; pc = 32'h8000_0046; #1;
    checks++;
    if (trap_pc !== 32'h8000_0100) begin
      failures++; $display("FAIL trap_pc got=%h required 80000100", trap_pc);
    end
    cycle(); idle();
    csr_addr = 12'h341; #1;
    checks++;
    if (csr_rdata !== 32'h8000_0044) begin
      failures++; $display("FAIL ecall_mepc got=%h required 80000044", csr_rdata);
    end
    csr_addr = 12'h342; #1;
    checks++;
    if (csr_rdata !== 32'd11) begin
      failures++; $display("FAIL ecall_mcause got=%h required 0000000b", csr_rdata);
    end
    csr_addr = 12'h300; #1;
    checks++;
    if (csr_rdata !== 32'h0000_1880) begin
      failures++; $display("FAIL ecall_mstatus got=%h required 00001880", csr_rdata);
    end
    idle(); mret = 1;
    cycle(); idle();
    csr_addr = 12'h300; #1;
    checks++;
    if (csr_rdata !== 32'h0000_1888 || ret_pc !== 32'h8000_0044) begin
      failures++; $display("FAIL mret mstatus=%h ret_pc=%h required 00001888/80000044", csr_rdata, ret_pc);
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 6; i++) begin
      write(12'h300, $urandom);
      idle(); ecall = 1; mret = 1; csr_wen = 1; csr_addr = 12'h341; csr_wdata = 32'h1234; pc = $urandom;
      cycle(); idle();
      csr_addr = 12'h341; #1;
      checks++;
      if (csr_rdata !== m_epc || csr_rdata[1:0] !== 2'b00) begin
        failures++; $display("FAIL collide_mepc got=%h required %h", csr_rdata, m_epc);
      end
      csr_addr = 12'h300; #1;
      checks++;
      if (csr_rdata !== m_status || csr_rdata[3] !== 1'b0) begin
        failures++; $display("FAIL collide_mstatus got=%h required %h", csr_rdata, m_status);
      end
    end
    idle(); ecall = 1; csr_wen = 1; csr_addr = 12'h340; csr_wdata = 32'h55; pc = 32'h100;
    cycle(); idle();
    csr_addr = 12'h340; #1;
    checks++;
    if (csr_rdata !== 32'h55) begin
      failures++; $display("FAIL collide_mscratch got=%h required 00000055", csr_rdata);
    end
  endtask

  task automatic test_mcycle();
    logic [31:0] h, d;
    repeat ($urandom_range(2, 9)) cycle();
    csr_addr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== m_cycle[31:0]) begin
      failures++; $display("FAIL mcycle_count got=%h required %h", csr_rdata, m_cycle[31:0]);
    end
    write(12'hB00, 32'hFFFF_FFFF);
    csr_addr = 12'hB80; #1; h = m_cycle[63:32];
    cycle();
    csr_addr = 12'hB80; #1;
    checks++;
    if (csr_rdata !== h + 32'd1) begin
      failures++; $display("FAIL mcycle_carry_hi got=%h required %h", csr_rdata, h + 32'd1);
    end
    csr_addr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== 32'h0) begin
      failures++; $display("FAIL mcycle_carry_lo got=%h required 0", csr_rdata);
    end
    write(12'hB00, 32'hFFFF_FFFF);
    d = $urandom;
    write(12'hB80, d);
    csr_addr = 12'hB80; #1;
    checks++;
    if (csr_rdata !== d) begin
      failures++; $display("FAIL mcycleh_write got=%h required %h", csr_rdata, d);
    end
    csr_addr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== 32'h0) begin
      failures++; $display("FAIL mcycleh_lo got=%h required 0", csr_rdata);
    end
    write(12'hB80, 32'hFFFF_FFFF);
    write(12'hB00, 32'hFFFF_FFFF);
    cycle();
    csr_addr = 12'hB80; #1;
    checks++;
    if (csr_rdata !== 32'h0 || m_cycle !== 64'h0) begin
      failures++; $display("FAIL mcycle_wrap hi=%h required 0", csr_rdata);
    end
  endtask

  task automatic test_illegal();
    idle(); csr_ren = 1; csr_addr = 12'h7C0; #1;
    checks++;
    if (csr_rdata !== 32'h0 || csr_illegal !== 1'b1) begin
      failures++; $display("FAIL illegal_read rdata=%h illegal=%b required 0/1", csr_rdata, csr_illegal);
    end
    idle(); csr_wen = 1; csr_addr = 12'hF11; csr_wdata = 32'h0; #1;
    checks++;
    if (csr_illegal !== 1'b1) begin
      failures++; $display("FAIL illegal_ro_write illegal=%b required 1", csr_illegal);
    end
    cycle(); idle();
    csr_addr = 12'hF11; #1;
    checks++;
    if (csr_rdata !== MVID) begin
      failures++; $display("FAIL ro_unchanged got=%h required %h", csr_rdata, MVID);
    end
    for (int i = 0; i < 20; i++) begin
      logic [11:0] a;
      logic r, w;
      bit exp;
      a = (i % 3 == 0) ? 12'hF12 : 12'($urandom);
      r = 1'($urandom); w = 1'($urandom);
      idle(); csr_addr = a; csr_ren = r; csr_wen = w; csr_wdata = $urandom; #1;
      exp = ((r || w) && !m_known(a)) || (w && m_ro(a));
      checks++;
      if (csr_illegal !== exp || csr_rdata !== m_read(a)) begin
        failures++;
        $display("FAIL rand_decode addr=%h illegal=%b rdata=%h required %b/%h", a, csr_illegal, csr_rdata, exp, m_read(a));
      end
      cycle();
    end
    write(12'h341, 32'h0000_0AB4);
    idle(); ecall = 1; pc = 32'h8000_0200; #2;
    rst = 0; #1;
    model_reset();
    csr_addr = 12'h341; #1;
    checks++;
    if (csr_rdata !== 32'h0 || ret_pc !== 32'h0) begin
      failures++; $display("FAIL reset_mid_ecall mepc=%h ret_pc=%h required 0/0", csr_rdata, ret_pc);
    end
    @(posedge clk); #1;
    csr_addr = 12'h342; #1;
    checks++;
    if (csr_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_hold_mcause got=%h required 0", csr_rdata);
    end
    idle(); rst = 1; #1;
    csr_addr = 12'h300; #1;
    checks++;
    if (csr_rdata !== 32'h1800) begin
      failures++; $display("FAIL reset_mid_mstatus got=%h required 00001800", csr_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ecall_mret();
    test_collision();
    test_mcycle();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
